// File: rtl/mmio_access_sequencer.sv
// -----------------------------------------------------------------------------
// mmio_access_sequencer
//
// Multi-cycle sequencer for CPU I/O loads and stores raised by the MEM-stage
// IoRead/IoWrite decode. The low effective address selects one of up to 16
// peripheral slots; the access is checked (slot implemented, alignment,
// funct3 legality, not read and write at once), then presented to the slot
// on a req/ack handshake. The pipeline is stalled until the access finishes,
// and loads return sign/zero-extended data for the addressed lane.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   io_read_i      I/O load request, held while stalled
//   io_write_i     I/O store request, held while stalled
//   funct3_i       RV32I load/store funct3 (size and signedness)
//   addr_i         low effective-address bits: {slot[3:0], in-slot byte addr}
//   wdata_i        store data (rs2)
//   stall_o        freeze pipeline (combinational)
//   rdata_o        extended load data, valid while rdata_valid_o
//   rdata_valid_o  one-cycle pulse on load completion
//   err_o          one-cycle pulse on unmapped/misaligned/illegal/timeout
//   dev_req_o      one-hot slot request, held until ack or timeout
//   dev_we_o       1 = write
//   dev_addr_o     word-aligned in-slot address
//   dev_be_o       byte enables
//   dev_wdata_o    store data moved onto its byte lanes
//   dev_ack_i      per-slot completion
//   dev_rdata_i    per-slot read words, slot n at [32*n +: 32]
// -----------------------------------------------------------------------------
module mmio_access_sequencer #(
    parameter int NUM_DEV = 8,
    parameter int DEV_AW  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    io_read_i,
    input  logic                    io_write_i,
    input  logic [2:0]              funct3_i,
    input  logic [DEV_AW+3:0]       addr_i,
    input  logic [31:0]             wdata_i,
    output logic                    stall_o,
    output logic [31:0]             rdata_o,
    output logic                    rdata_valid_o,
    output logic                    err_o,
    output logic [NUM_DEV-1:0]      dev_req_o,
    output logic                    dev_we_o,
    output logic [DEV_AW-1:0]       dev_addr_o,
    output logic [3:0]              dev_be_o,
    output logic [31:0]             dev_wdata_o,
    input  logic [NUM_DEV-1:0]      dev_ack_i,
    input  logic [32*NUM_DEV-1:0]   dev_rdata_i
);

    // Sequencer states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] NUM_DEV_W    = 5'(NUM_DEV);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // funct3[1:0] size codes.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  state;
    logic [7:0]  busyCount;
    logic [3:0]  slotReg;
    logic [1:0]  laneReg;
    logic [2:0]  funct3Reg;

    // Request decode (only meaningful in IDLE).
    logic        reqAny;
    logic [3:0]  reqSlot;
    logic [1:0]  reqLane;
    logic [1:0]  sizeCode;
    logic        slotBad;
    logic        misaligned;
    logic        funct3Ok;
    logic        checkFail;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;

    // Selected-slot ack/data (only meaningful in BUSY).
    logic        ackHit;
    logic [31:0] ackWord;

    // Pick the addressed lane out of the returned word and extend it.
    // Misaligned half/word loads never reach this point, so a half lane is
    // always 0 or 2 and a word lane is always 0.
    function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (f3)
            3'd0:    extendLoad = {{24{shifted[7]}},  shifted[7:0]};
            3'd1:    extendLoad = {{16{shifted[15]}}, shifted[15:0]};
            3'd2:    extendLoad = word;
            3'd4:    extendLoad = {24'd0, shifted[7:0]};
            3'd5:    extendLoad = {16'd0, shifted[15:0]};
            default: extendLoad = 32'd0;
        endcase
    endfunction

    assign reqAny   = io_read_i | io_write_i;
    assign reqSlot  = addr_i[DEV_AW+3:DEV_AW];
    assign reqLane  = addr_i[1:0];
    assign sizeCode = funct3_i[1:0];
    assign slotBad  = {1'b0, reqSlot} >= NUM_DEV_W;

    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        misaligned = 1'b0;
        reqBe      = 4'hF;
        case (sizeCode)
            SZ_BYTE: begin
                misaligned = 1'b0;
                reqBe      = 4'b0001 << reqLane;
            end
            SZ_HALF: begin
                misaligned = reqLane[0];
                reqBe      = 4'b0011 << {reqLane[1], 1'b0};
            end
            SZ_WORD: begin
                misaligned = |reqLane;
                reqBe      = 4'hF;
            end
            default: begin
                // Size code 3 is rejected by the funct3 check below.
                misaligned = 1'b0;
                reqBe      = 4'hF;
            end
        endcase
    end

    // Stores accept sb/sh/sw only; loads accept lb/lh/lw/lbu/lhu.
    always_comb begin
        funct3Ok = 1'b0;
        if (io_write_i) begin
            funct3Ok = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);
        end else begin
            funct3Ok = (funct3_i != 3'd3) && (funct3_i != 3'd6) && (funct3_i != 3'd7);
        end
    end

    assign checkFail = (io_read_i & io_write_i) | slotBad | misaligned | ~funct3Ok;
    assign reqWdata  = wdata_i << {reqLane, 3'b000};

    // Only the latched slot's ack and data are visible; acks from any other
    // slot are simply never looked at.
    always_comb begin
        ackHit  = 1'b0;
        ackWord = 32'd0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (slotReg == 4'(i)) begin
                ackHit  = dev_ack_i[i];
                ackWord = dev_rdata_i[i*32 +: 32];
            end
        end
    end

    // Request is decoded from state so a reset taken in BUSY removes it at
    // the same edge that returns the FSM to IDLE.
    always_comb begin
        dev_req_o = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            dev_req_o[i] = (state == S_BUSY) && (slotReg == 4'(i));
        end
    end

    // DONE deliberately leaves stall low so the stalled instruction retires.
    assign stall_o = ((state == S_IDLE) && reqAny) || (state == S_BUSY);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            busyCount     <= 8'd0;
            slotReg       <= 4'd0;
            laneReg       <= 2'd0;
            funct3Reg     <= 3'd0;
            rdata_o       <= 32'd0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            dev_we_o      <= 1'b0;
            dev_addr_o    <= '0;
            dev_be_o      <= 4'd0;
            dev_wdata_o   <= 32'd0;
        end else begin
            // Result flags are high exactly for the single DONE cycle.
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (reqAny) begin
                        slotReg     <= reqSlot;
                        laneReg     <= reqLane;
                        funct3Reg   <= funct3_i;
                        dev_we_o    <= io_write_i;
                        dev_addr_o  <= {addr_i[DEV_AW-1:2], 2'b00};
                        dev_be_o    <= reqBe;
                        dev_wdata_o <= reqWdata;
                        busyCount   <= 8'd0;
                        if (checkFail) begin
                            err_o   <= 1'b1;
                            rdata_o <= 32'd0;
                            state   <= S_DONE;
                        end else begin
                            state   <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (ackHit) begin
                        if (!dev_we_o) begin
                            rdata_valid_o <= 1'b1;
                            rdata_o       <= extendLoad(ackWord, funct3Reg, laneReg);
                        end
                        state <= S_DONE;
                    end else if (busyCount == TIMEOUT_LAST) begin
                        err_o   <= 1'b1;
                        rdata_o <= 32'd0;
                        state   <= S_DONE;
                    end else begin
                        busyCount <= busyCount + 8'd1;
                    end
                end

                // Always back to IDLE: a request still held here belongs to
                // the instruction that is now retiring, not a new access.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mmio_access_sequencer
//
// Self-checking bench for mmio_access_sequencer. Each access is predicted at
// transaction level (legality, byte enables, lane data, BUSY length, result)
// from plain arithmetic, then followed cycle by cycle against the DUT.
// Directed cases come first, then randomized accesses with stray acks.
// -----------------------------------------------------------------------------
module tb_mmio_access_sequencer;

    localparam int NUM_DEV = 8;
    localparam int DEV_AW  = 6;
    localparam int TIMEOUT = 255;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  io_read_i;
    logic                  io_write_i;
    logic [2:0]            funct3_i;
    logic [DEV_AW+3:0]     addr_i;
    logic [31:0]           wdata_i;
    logic                  stall_o;
    logic [31:0]           rdata_o;
    logic                  rdata_valid_o;
    logic                  err_o;
    logic [NUM_DEV-1:0]    dev_req_o;
    logic                  dev_we_o;
    logic [DEV_AW-1:0]     dev_addr_o;
    logic [3:0]            dev_be_o;
    logic [31:0]           dev_wdata_o;
    logic [NUM_DEV-1:0]    dev_ack_i;
    logic [32*NUM_DEV-1:0] dev_rdata_i;

    int checks   = 0;
    int failures = 0;
    int txnId    = 0;

    // Last value rdata_o is expected to hold.
    logic [31:0] expRdata = 32'd0;

    mmio_access_sequencer #(
        .NUM_DEV (NUM_DEV),
        .DEV_AW  (DEV_AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .io_read_i     (io_read_i),
        .io_write_i    (io_write_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .dev_req_o     (dev_req_o),
        .dev_we_o      (dev_we_o),
        .dev_addr_o    (dev_addr_o),
        .dev_be_o      (dev_be_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_ack_i     (dev_ack_i),
        .dev_rdata_i   (dev_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL [txn %0d] %s got=0x%08h exp=0x%08h", txnId, tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic randomizeRdata();
        for (int i = 0; i < NUM_DEV; i++) begin
            dev_rdata_i[i*32 +: 32] = $urandom;
        end
    endtask

    // Full access: drive it, predict it, follow it to the end of DONE.
    // ackDelay = BUSY cycle index (0-based) on which the slot acks; a value
    // >= TIMEOUT means the slot never answers. noise adds stray acks.
    task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [9:0] addr, input logic [31:0] wd,
                            input int ackDelay, input logic [31:0] ackWord,
                            input logic noise);
        int          slot;
        int          lane;
        int          busyCycles;
        int          stallCount;
        logic        bad;
        logic        f3Legal;
        logic        timedOut;
        logic        isLoad;
        logic [31:0] expBe;
        logic [31:0] expWd;
        logic [31:0] expAddr;
        logic [31:0] byteV;
        logic [31:0] halfV;
        logic [31:0] loadV;
        logic [NUM_DEV-1:0] strayAck;

        txnId++;
        slot = int'(addr[9:6]);
        lane = int'(addr[1:0]);

        // Legality from the access rules.
        if (wr) f3Legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    f3Legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                          (f3 == 3'd4) || (f3 == 3'd5);
        bad = (rd && wr) || (slot >= NUM_DEV) || !f3Legal ||
              ((f3[1:0] == 2'd1) && (lane % 2 != 0)) ||
              ((f3[1:0] == 2'd2) && (lane != 0));
        timedOut   = !bad && (ackDelay >= TIMEOUT);
        busyCycles = bad ? 0 : (timedOut ? TIMEOUT : ackDelay + 1);
        isLoad     = rd && !wr;

        case (f3[1:0])
            2'd0:    expBe = 32'(1 << lane);
            2'd1:    expBe = (lane >= 2) ? 32'hC : 32'h3;
            default: expBe = 32'hF;
        endcase
        expWd   = wd << (8 * lane);
        expAddr = 32'(addr[5:0]) & 32'h3C;

        byteV = (ackWord >> (8 * lane)) & 32'hFF;
        halfV = (ackWord >> (8 * lane)) & 32'hFFFF;
        case (f3)
            3'd0:    loadV = (byteV >= 32'd128)   ? byteV + 32'hFFFF_FF00 : byteV;
            3'd1:    loadV = (halfV >= 32'd32768) ? halfV + 32'hFFFF_0000 : halfV;
            3'd4:    loadV = byteV;
            3'd5:    loadV = halfV;
            default: loadV = ackWord;
        endcase

        // IDLE cycle with request presented; acks here must be ignored.
        io_read_i  = rd;
        io_write_i = wr;
        funct3_i   = f3;
        addr_i     = addr;
        wdata_i    = wd;
        randomizeRdata();
        dev_ack_i  = noise ? NUM_DEV'($urandom) : '0;
        #1;
        check("idle_stall", 32'(stall_o), 32'd1);
        check("idle_req", 32'(dev_req_o), 32'd0);
        tick();
        dev_ack_i  = '0;
        stallCount = 1;

        for (int k = 0; k < busyCycles; k++) begin
            check("busy_stall", 32'(stall_o), 32'd1);
            check("busy_req", 32'(dev_req_o), 32'(1 << slot));
            check("busy_flags", {30'd0, rdata_valid_o, err_o}, 32'd0);
            if (k == 0) begin
                check("dev_we", 32'(dev_we_o), 32'(wr));
                check("dev_addr", 32'(dev_addr_o), expAddr);
                check("dev_be", 32'(dev_be_o), expBe);
                check("dev_wdata", dev_wdata_o, expWd);
            end
            randomizeRdata();
            strayAck = noise ? (NUM_DEV'($urandom) & ~NUM_DEV'(1 << slot)) : '0;
            dev_ack_i = strayAck;
            if (k == ackDelay) begin
                dev_ack_i[slot] = 1'b1;
                dev_rdata_i[slot*32 +: 32] = ackWord;
            end
            tick();
            dev_ack_i = '0;
            stallCount++;
        end

        // DONE cycle: request still held, stall must already be released.
        if (bad || timedOut) expRdata = 32'd0;
        else if (isLoad)     expRdata = loadV;
        check("stall_cycles", 32'(stallCount), 32'(busyCycles + 1));
        check("done_stall", 32'(stall_o), 32'd0);
        check("done_req", 32'(dev_req_o), 32'd0);
        check("done_err", 32'(err_o), 32'(bad || timedOut));
        check("done_valid", 32'(rdata_valid_o), 32'(isLoad && !bad && !timedOut));
        check("done_rdata", rdata_o, expRdata);

        io_read_i  = 1'b0;
        io_write_i = 1'b0;
        dev_ack_i  = noise ? NUM_DEV'($urandom) : '0;
        tick();
        dev_ack_i = '0;

        // Back in IDLE: pulses gone, data held.
        check("after_flags", {30'd0, rdata_valid_o, err_o}, 32'd0);
        check("after_rdata", rdata_o, expRdata);
        check("after_stall", 32'(stall_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        io_read_i   = 1'b0;
        io_write_i  = 1'b0;
        funct3_i    = 3'd0;
        addr_i      = '0;
        wdata_i     = 32'd0;
        dev_ack_i   = '0;
        dev_rdata_i = '0;

        // Reset state.
        tick();
        tick();
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_flags", {30'd0, rdata_valid_o, err_o}, 32'd0);
        check("rst_req", 32'(dev_req_o), 32'd0);
        check("rst_dev", {27'd0, dev_we_o, dev_be_o}, 32'd0);
        check("rst_addr", 32'(dev_addr_o), 32'd0);
        check("rst_wdata", dev_wdata_o, 32'd0);
        rst_i = 1'b0;
        tick();

        // lw slot1, ack on second BUSY cycle.
        doAccess(1'b1, 1'b0, 3'd2, 10'h044, 32'd0, 1, 32'h1234_5678, 1'b0);

        // lb / lbu top lane of slot2.
        doAccess(1'b1, 1'b0, 3'd0, 10'h083, 32'd0, 0, 32'h80AA_BBCC, 1'b0);
        doAccess(1'b1, 1'b0, 3'd4, 10'h083, 32'd0, 2, 32'h80AA_BBCC, 1'b0);

        // sh upper half of slot3.
        doAccess(1'b0, 1'b1, 3'd1, 10'h0C2, 32'h0000_BEEF, 0, 32'hDEAD_0001, 1'b0);

        // Unmapped slot and misaligned word.
        doAccess(1'b1, 1'b0, 3'd2, 10'h3C0, 32'd0, 0, 32'hFFFF_FFFF, 1'b0);
        doAccess(1'b1, 1'b0, 3'd2, 10'h042, 32'd0, 0, 32'hFFFF_FFFF, 1'b0);

        // Illegal funct3 and simultaneous read/write.
        doAccess(1'b1, 1'b0, 3'd3, 10'h040, 32'd0, 0, 32'h1111_1111, 1'b0);
        doAccess(1'b1, 1'b1, 3'd2, 10'h040, 32'd0, 0, 32'h1111_1111, 1'b0);

        // lw slot0, never acked.
        doAccess(1'b1, 1'b0, 3'd2, 10'h000, 32'd0, 1000, 32'h5555_AAAA, 1'b0);

        // Reset mid-BUSY, with a stray ack from slot3 while slot1 is requested.
        txnId++;
        io_read_i = 1'b1;
        funct3_i  = 3'd2;
        addr_i    = 10'h044;
        #1;
        check("rstb_idle_stall", 32'(stall_o), 32'd1);
        tick();
        check("rstb_req", 32'(dev_req_o), 32'h2);
        dev_ack_i = NUM_DEV'(1 << 3);
        dev_rdata_i[3*32 +: 32] = 32'hCAFE_F00D;
        tick();
        dev_ack_i = '0;
        check("rstb_stray_req", 32'(dev_req_o), 32'h2);
        check("rstb_stray_stall", 32'(stall_o), 32'd1);
        check("rstb_stray_flags", {30'd0, rdata_valid_o, err_o}, 32'd0);
        rst_i     = 1'b1;
        io_read_i = 1'b0;
        tick();
        check("rstb_req_drop", 32'(dev_req_o), 32'd0);
        check("rstb_stall", 32'(stall_o), 32'd0);
        check("rstb_flags", {30'd0, rdata_valid_o, err_o}, 32'd0);
        check("rstb_rdata", rdata_o, 32'd0);
        expRdata = 32'd0;
        rst_i = 1'b0;
        tick();
        // Nothing replayed after reset.
        check("rstb_idle_req", 32'(dev_req_o), 32'd0);
        doAccess(1'b1, 1'b0, 3'd5, 10'h046, 32'd0, 0, 32'h9876_5432, 1'b1);

        // Randomized accesses with stray acks.
        for (int n = 0; n < 80; n++) begin
            logic       rd;
            logic       wr;
            logic [2:0] f3;
            logic [9:0] addr;
            int         pick;
            pick = int'($urandom_range(0, 9));
            rd = (pick == 0) || (pick <= 5);
            wr = (pick == 0) || (pick > 5);
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            addr = 10'($urandom);
            if ($urandom_range(0, 9) < 8) addr[9] = 1'b0;
            doAccess(rd, wr, f3, addr, $urandom, int'($urandom_range(0, 6)),
                     $urandom, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
